// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: instruction-trace capture for the schoolMIPS core.
// Records {pc, instr} into a circular buffer on every CPU-enabled cycle,
// with PC-match trigger, post-trigger capture, cycle timeout and read-back.
// Optional macro SM_TRACE_GPIO_EN adds a GPIO snapshot to every entry.
//
// state | meaning
// IDLE  | no capture, waiting for arm
// PRE   | capturing, waiting for PC-match trigger
// POST  | capturing the post-trigger window
// DONE  | capture frozen until next arm
module sm_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int POST_TRIG  = 8,
  parameter int MAX_CYCLES = 120
`ifdef SM_TRACE_GPIO_EN
  , parameter int GPIO_W   = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_en_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       instr_i,
  input  logic              arm_i,
  input  logic              trig_en_i,
  input  logic [31:0]       trig_pc_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_valid_o,
  output logic [31:0]       rd_pc_o,
  output logic [31:0]       rd_instr_o,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   count_o,
  output logic [ADDR_W-1:0] trig_idx_o,
  output logic              triggered_o,
  output logic              timeout_o,
  output logic [31:0]       cycle_o
`ifdef SM_TRACE_GPIO_EN
  , input  logic [GPIO_W-1:0] gpio_in_i
  , output logic [GPIO_W-1:0] rd_gpio_o
`endif
);

`ifdef SM_TRACE_GPIO_EN
  localparam int ENTRY_W = 64 + GPIO_W;
`else
  localparam int ENTRY_W = 64;
`endif
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   trig_idx_q;
  logic                triggered_q;
  logic                timeout_q;
  logic [31:0]         cycle_q;
  logic [ADDR_W-1:0]   post_cnt_q;
  logic                rd_valid_q;
  logic [31:0]         rd_pc_q;
  logic [31:0]         rd_instr_q;
  logic [ENTRY_W-1:0]  mem [DEPTH];

  logic                wr_en_d;
  logic                full_d;
  logic                trig_hit_d;
  logic                tmo_hit_d;
  logic [31:0]         cycle_d;
  logic [ENTRY_W-1:0]  entry_d;
  logic                rd_take_d;
  logic                rd_in_range_d;
  logic [ADDR_W-1:0]   rd_phys_d;

  // arm always wins, so a write in the arm clock never lands
  assign wr_en_d    = cpu_en_i && !arm_i && (state_q == ST_PRE || state_q == ST_POST);
  assign full_d     = (count_q == CNT_FULL);
  assign trig_hit_d = wr_en_d && (state_q == ST_PRE) && trig_en_i && (pc_i == trig_pc_i);
  assign cycle_d    = cycle_q + 32'd1;
  assign tmo_hit_d  = wr_en_d && (cycle_d == 32'(MAX_CYCLES));

`ifdef SM_TRACE_GPIO_EN
  assign entry_d = {gpio_in_i, pc_i, instr_i};
`else
  assign entry_d = {pc_i, instr_i};
`endif

  // once the buffer has wrapped the oldest entry sits at the write pointer
  assign rd_take_d     = rd_req_i && !rd_valid_q;
  assign rd_in_range_d = ({1'b0, rd_addr_i} < count_q);
  assign rd_phys_d     = (full_d ? wr_ptr_q : '0) + rd_addr_i;

  // capture control FSM: pointers, counters, trigger and timeout flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trig_idx_q  <= '0;
      triggered_q <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_q     <= '0;
      post_cnt_q  <= '0;
    end else if (arm_i) begin
      state_q     <= ST_PRE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_q     <= '0;
      post_cnt_q  <= '0;
    end else if (wr_en_d) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      cycle_q  <= cycle_d;
      if (!full_d) count_q <= count_q + 1'b1;
      if (state_q == ST_PRE) begin
        if (trig_hit_d) begin
          triggered_q <= 1'b1;
          trig_idx_q  <= full_d ? ADDR_W'(DEPTH - 1) : count_q[ADDR_W-1:0];
          if (POST_TRIG == 0) begin
            state_q <= ST_DONE;
          end else begin
            state_q    <= ST_POST;
            post_cnt_q <= ADDR_W'(POST_TRIG);
          end
        end
      end else begin
        // overwriting the oldest entry shifts every logical index down;
        // a trigger entry that falls off the end pins at zero
        if (full_d && trig_idx_q != '0) trig_idx_q <= trig_idx_q - 1'b1;
        post_cnt_q <= post_cnt_q - 1'b1;
        if (post_cnt_q == ADDR_W'(1)) state_q <= ST_DONE;
      end
      if (tmo_hit_d) begin
        timeout_q <= 1'b1;
        state_q   <= ST_DONE;
      end
    end
  end

  // trace RAM, deliberately not reset
  always_ff @(posedge clk_i) begin
    if (wr_en_d) mem[wr_ptr_q] <= entry_d;
  end

  // read port: one outstanding request, data one clock later, old data on collision
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
    end else begin
      rd_valid_q <= rd_take_d;
      if (rd_take_d) begin
        rd_pc_q    <= rd_in_range_d ? mem[rd_phys_d][63:32] : 32'd0;
        rd_instr_q <= rd_in_range_d ? mem[rd_phys_d][31:0]  : 32'd0;
      end
    end
  end

`ifdef SM_TRACE_GPIO_EN
  logic [GPIO_W-1:0] rd_gpio_q;

  // GPIO snapshot read-back, same timing as pc/instr
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_gpio_q <= '0;
    end else if (rd_take_d) begin
      rd_gpio_q <= rd_in_range_d ? mem[rd_phys_d][ENTRY_W-1:64] : '0;
    end
  end

  assign rd_gpio_o = rd_gpio_q;
`endif

  assign rd_valid_o  = rd_valid_q;
  assign rd_pc_o     = rd_pc_q;
  assign rd_instr_o  = rd_instr_q;
  assign state_o     = state_q;
  assign count_o     = count_q;
  assign trig_idx_o  = trig_idx_q;
  assign triggered_o = triggered_q;
  assign timeout_o   = timeout_q;
  assign cycle_o     = cycle_q;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Testbench for sm_trace_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the capture history.
module tb_sm_trace_buffer;
  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;
  localparam int POST_TRIG  = 8;
  localparam int MAX_CYCLES = 120;

  logic              clk = 1'b0;
  logic              rst, cpu_en, arm, trig_en, rd_req;
  logic [31:0]       pc, instr, trig_pc;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid_o, triggered_o, timeout_o;
  logic [31:0]       rd_pc_o, rd_instr_o, cycle_o;
  logic [1:0]        state_o;
  logic [ADDR_W:0]   count_o;
  logic [ADDR_W-1:0] trig_idx_o;
`ifdef SM_TRACE_GPIO_EN
  logic [15:0]       gpio_in = 16'h000a;
  logic [15:0]       rd_gpio_o;
`endif

  sm_trace_buffer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST_TRIG(POST_TRIG), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cpu_en_i(cpu_en), .pc_i(pc), .instr_i(instr),
    .arm_i(arm), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid_o), .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o),
    .state_o(state_o), .count_o(count_o), .trig_idx_o(trig_idx_o),
    .triggered_o(triggered_o), .timeout_o(timeout_o), .cycle_o(cycle_o)
`ifdef SM_TRACE_GPIO_EN
    , .gpio_in_i(gpio_in), .rd_gpio_o(rd_gpio_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: full history of captured entries since arm
  logic [63:0] hist[$];
  int          m_state, m_cycle, m_trig_abs, m_post;
  bit          m_trig, m_tmo, m_rdv, m_rd_hit;
  logic [31:0] m_rpc, m_rinstr;

  function automatic int m_count();
    return (hist.size() < DEPTH) ? hist.size() : DEPTH;
  endfunction

  function automatic logic [63:0] m_lookup(input int a);
    int c = m_count();
    if (a < c) return hist[hist.size() - c + a];
    return 64'd0;
  endfunction

  function automatic int m_tidx();
    int t = m_trig_abs - (hist.size() - m_count());
    return (t < 0) ? 0 : t;
  endfunction

  task automatic model_step();
    logic [63:0] e;
    if (rst) begin
      hist.delete();
      m_state = 0; m_cycle = 0; m_trig = 0; m_tmo = 0; m_post = 0; m_trig_abs = 0;
      m_rdv = 0; m_rpc = 0; m_rinstr = 0; m_rd_hit = 0;
      return;
    end
    if (rd_req && !m_rdv) begin
      e        = m_lookup(int'(rd_addr));
      m_rd_hit = int'(rd_addr) < m_count();
      m_rdv    = 1;
      m_rpc    = e[63:32];
      m_rinstr = e[31:0];
    end else begin
      m_rdv = 0;
    end
    if (arm) begin
      hist.delete();
      m_state = 1; m_cycle = 0; m_trig = 0; m_tmo = 0; m_post = 0;
    end else if (cpu_en && (m_state == 1 || m_state == 2)) begin
      hist.push_back({pc, instr});
      m_cycle++;
      if (m_state == 1) begin
        if (trig_en && pc == trig_pc) begin
          m_trig     = 1;
          m_trig_abs = hist.size() - 1;
          if (POST_TRIG == 0) m_state = 3;
          else begin m_state = 2; m_post = POST_TRIG; end
        end
      end else begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
      if (m_cycle == MAX_CYCLES) begin m_tmo = 1; m_state = 3; end
    end
  endtask

  task automatic check_all();
    chk("state", 64'(state_o), 64'(m_state));
    chk("count", 64'(count_o), 64'(m_count()));
    chk("triggered", 64'(triggered_o), 64'(m_trig));
    chk("timeout", 64'(timeout_o), 64'(m_tmo));
    chk("cycle", 64'(cycle_o), 64'(m_cycle));
    chk("rd_valid", 64'(rd_valid_o), 64'(m_rdv));
    chk("rd_pc", 64'(rd_pc_o), 64'(m_rpc));
    chk("rd_instr", 64'(rd_instr_o), 64'(m_rinstr));
    if (m_trig) chk("trig_idx", 64'(trig_idx_o), 64'(m_tidx()));
`ifdef SM_TRACE_GPIO_EN
    if (m_rdv) chk("rd_gpio", 64'(rd_gpio_o), m_rd_hit ? 64'h000a : 64'h0);
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    rst = 0; arm = 0; cpu_en = 0; rd_req = 0;
  endtask

  task automatic do_read(input int a, output logic [31:0] p, output logic [31:0] i);
    rd_req = 1; rd_addr = ADDR_W'(a);
    step();
    p = rd_pc_o; i = rd_instr_o;
    rd_req = 0;
    step();
  endtask

  task automatic reset_arm();
    quiet(); rst = 1; step();
    rst = 0; arm = 1; step();
    arm = 0;
  endtask

  task automatic run_pcs(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      cpu_en = 1; pc = 32'(first + k); instr = 32'(first + k) ^ 32'hA5A5_0000;
      step();
    end
    cpu_en = 0;
  endtask

  logic [31:0] rp, ri;

  initial begin
    quiet(); trig_en = 0; trig_pc = 0; pc = 0; instr = 0; rd_addr = 0;
    rst = 1; step(); step();
    rst = 0;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_trig_idx", 64'(trig_idx_o), 64'd0);
    chk("rst_rd_pc", 64'(rd_pc_o), 64'd0);

    // five captures, no trigger
    reset_arm();
    run_pcs(0, 5);
    chk("t1_count", 64'(count_o), 64'd5);
    chk("t1_state", 64'(state_o), 64'd1);
    do_read(0, rp, ri);
    chk("t1_rd0_pc", 64'(rp), 64'd0);
    do_read(5, rp, ri);
    chk("t1_rd5_pc", 64'(rp), 64'd0);
    chk("t1_rd5_instr", 64'(ri), 64'd0);

    // trigger at pc 3 plus eight post entries
    quiet(); trig_en = 1; trig_pc = 3;
    reset_arm();
    run_pcs(0, 41);
    chk("t2_state", 64'(state_o), 64'd3);
    chk("t2_count", 64'(count_o), 64'd12);
    chk("t2_trig_idx", 64'(trig_idx_o), 64'd3);
    chk("t2_triggered", 64'(triggered_o), 64'd1);
    do_read(11, rp, ri);
    chk("t2_rd11_pc", 64'(rp), 64'd11);

    // wrap without trigger
    trig_en = 0;
    reset_arm();
    run_pcs(0, 20);
    chk("t3_count", 64'(count_o), 64'd16);
    do_read(0, rp, ri);
    chk("t3_rd0_pc", 64'(rp), 64'd4);
    do_read(15, rp, ri);
    chk("t3_rd15_pc", 64'(rp), 64'd19);

    // timeout
    reset_arm();
    run_pcs(0, 130);
    chk("t4_timeout", 64'(timeout_o), 64'd1);
    chk("t4_state", 64'(state_o), 64'd3);
    chk("t4_cycle", 64'(cycle_o), 64'd120);
    do_read(15, rp, ri);
    chk("t4_rd15_pc", 64'(rp), 64'd119);

    // read of the slot being overwritten returns the old entry
    reset_arm();
    run_pcs(100, 16);
    rd_req = 1; rd_addr = 0; cpu_en = 1; pc = 200; instr = 32'h1234;
    step();
    chk("t6_collide_pc", 64'(rd_pc_o), 64'd100);
    quiet(); step();

    // arm during POST with cpu_en, then reset during POST
    trig_en = 1; trig_pc = 2;
    reset_arm();
    run_pcs(0, 5);
    chk("t5_post", 64'(state_o), 64'd2);
    arm = 1; cpu_en = 1; pc = 50; step();
    quiet();
    chk("t5_arm_state", 64'(state_o), 64'd1);
    chk("t5_arm_count", 64'(count_o), 64'd0);
    chk("t5_arm_trig", 64'(triggered_o), 64'd0);
    run_pcs(0, 4);
    do_read(1, rp, ri);
    rst = 1; step(); rst = 0;
    chk("t5_rst_state", 64'(state_o), 64'd0);
    chk("t5_rst_count", 64'(count_o), 64'd0);
    chk("t5_rst_cycle", 64'(cycle_o), 64'd0);
    chk("t5_rst_trig", 64'(triggered_o), 64'd0);
    chk("t5_rst_tidx", 64'(trig_idx_o), 64'd0);
    chk("t5_rst_rdpc", 64'(rd_pc_o), 64'd0);

    // randomized traffic against the model
    quiet(); arm = 1; step();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      arm = ($urandom_range(0, 149) == 0);
      if (arm) begin
        trig_en = 1'($urandom_range(0, 1));
        trig_pc = 32'($urandom_range(0, 40));
      end
      cpu_en  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0 || pc > 60) pc = 32'($urandom_range(0, 40));
      else pc = pc + 1;
      instr   = $urandom;
      rd_req  = ($urandom_range(0, 2) == 0);
      rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
